shift_decode_stage: RTL
=======================

SHIFT_DECODE_STAGE -- requirements
Module: shift_decode_stage

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 32 bits with a 2-entry buffer.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream offers an instruction.
REQ-006 in_ready  output  1  stage can accept; registered, a function of occupancy only.
REQ-007 in_inst  input  32  RV32 instruction word.
REQ-008 in_rs1  input  32  rs1 register value.
REQ-009 in_rs2  input  32  rs2 register value.
REQ-010 flush  input  1  synchronous discard of all buffered entries.
REQ-011 out_valid  output  1  head entry is present.
REQ-012 out_ready  input  1  downstream shifter or writeback consumes the head entry.
REQ-013 out_data  output  32  operand to shift; feeds shifter data.
REQ-014 out_shamt  output  5  shift amount; feeds shifter shamt.
REQ-015 out_l_or_r  output  1  1 = left, 0 = right.
REQ-016 out_a_or_l  output  1  1 = arithmetic, 0 = logical.
REQ-017 out_rd  output  5  destination register, in_inst[11:7].
REQ-018 out_illegal  output  1  instruction is not a supported shift.

Function
REQ-019 SHALL accept an entry on a rising edge where in_valid && in_ready && !flush.
REQ-020 SHALL pop the head entry on a rising edge where out_valid && out_ready && !flush.
REQ-021 Decode for opcode 0110011 (register form):
- funct3=001, funct7=0000000 -> SLL (l_or_r=1, a_or_l=0).
- funct3=101, funct7=0000000 -> SRL (0, 0).
- funct3=101, funct7=0100000 -> SRA (0, 1).
- out_data = in_rs1; out_shamt = in_rs2[4:0].
REQ-022 Decode for opcode 0010011 (immediate form):
- same funct3/inst[31:25] patterns -> SLLI/SRLI/SRAI.
- out_data = in_rs1; out_shamt = in_inst[24:20].
- inst[25]=1 is illegal.
REQ-023 Any other encoding: store illegal=1, data=0, shamt=0, l_or_r=0, a_or_l=0; rd is still taken from inst[11:7].
REQ-024 SHALL decode combinationally at the input and store the decoded fields; outputs come from the head register entry with no combinational path from any input to any output.
REQ-025 Latency SHALL be 1 cycle: an entry accepted at edge N is at the outputs with out_valid=1 from edge N onward, if the buffer was empty.
REQ-026 Entries SHALL leave in acceptance order, with no loss or duplication.
REQ-027 Occupancy and handshake rules:
- occupancy 0..2 is tracked with wrap-around read/write pointers.
- in_ready = (occupancy < 2); out_valid = (occupancy > 0).
REQ-028 Occupancy 1 with push and pop on the same edge: occupancy stays 1 and the new entry becomes the head.
REQ-029 At occupancy 2, in_ready=0 and pushes are ignored even if in_valid=1; a pop frees a slot and in_ready=1 on the following cycle.
REQ-030 flush=1 SHALL:
- set occupancy and pointers to 0 at the edge.
- override push and pop on that edge.
- leave out_valid=0 and in_ready=1 afterwards.
REQ-031 Payload outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-032 On rst_n=0, state SHALL reset immediately, independent of clk:
- occupancy and pointers = 0.
- out_valid = 0, in_ready = 1.
- all storage and payload outputs = 0.
REQ-033 Reset asserted mid-transfer SHALL discard all entries; no pre-reset entry appears after rst_n deasserts.
REQ-034 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 SRAI x5,x6,4 (in_inst=0x40435293, rs1=0x80000010) -> next cycle: out_data=0x80000010, shamt=4, l_or_r=0, a_or_l=1, rd=5, illegal=0.
REQ-036 SLL x1,x2,x3 (0x003110B3, rs1=0x1, rs2=0x25) -> out_shamt=5, l_or_r=1, a_or_l=0, rd=1.
REQ-037 ADD (0x003100B3) and SLLI with inst[25]=1 (0x02011093) -> illegal=1, out_data=0, rd=1.
REQ-038 Backpressure check:
- Stimulus: out_ready=0; push A, B, C back-to-back.
- Response: in_ready=0 after B, so C is held; after out_ready=1, A then B pop in order, then C is accepted.
REQ-039 Flush and push on the same edge at occupancy 1 -> occupancy 0, out_valid=0, pushed entry dropped; in_ready=1.
REQ-040 Async reset check:
- Stimulus: rst_n pulsed low between edges with occupancy 2.
- Response: out_valid=0 immediately; after release, a push gives exactly one entry.

Source files
------------

// File: rtl/shift_decode_stage.sv
// Shift decode stage: decodes RV32 register/immediate shift instructions at the
// input and holds decoded operands in a 2-entry in-order buffer for the shifter.
module shift_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_shamt,
    output logic        out_l_or_r,
    output logic        out_a_or_l,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        l_or_r;
        logic        a_or_l;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    entry_t      dec_d;
    entry_t      mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        push, pop;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_reg, is_imm;
    logic        unused_bits;

    assign opcode      = in_inst[6:0];
    assign funct3      = in_inst[14:12];
    assign funct7      = in_inst[31:25];
    assign is_reg      = (opcode == OP_REG);
    assign is_imm      = (opcode == OP_IMM);
    assign unused_bits = ^{in_inst[19:15], in_rs2[31:5]};

    // Decode the offered instruction into the stored entry format.
    // For the immediate form inst[25] is funct7[0], so a set bit fails every match.
    always_comb begin
        dec_d         = '0;
        dec_d.rd      = in_inst[11:7];
        dec_d.illegal = 1'b1;
        if (is_reg || is_imm) begin
            if (funct3 == 3'b001 && funct7 == 7'b0000000) begin
                dec_d.illegal = 1'b0;
                dec_d.l_or_r  = 1'b1;
            end else if (funct3 == 3'b101 && funct7 == 7'b0000000) begin
                dec_d.illegal = 1'b0;
            end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
                dec_d.illegal = 1'b0;
                dec_d.a_or_l  = 1'b1;
            end
        end
        if (!dec_d.illegal) begin
            dec_d.data  = in_rs1;
            dec_d.shamt = is_reg ? in_rs2[4:0] : in_inst[24:20];
        end
    end

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = out_valid_q && out_ready && !flush;

    // Next-state for pointers, occupancy and the registered handshake flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        in_ready_d  = (count_d < 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Entry storage; a write never touches the head slot unless it is being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= dec_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = mem_q[rd_ptr_q].data;
    assign out_shamt   = mem_q[rd_ptr_q].shamt;
    assign out_l_or_r  = mem_q[rd_ptr_q].l_or_r;
    assign out_a_or_l  = mem_q[rd_ptr_q].a_or_l;
    assign out_rd      = mem_q[rd_ptr_q].rd;
    assign out_illegal = mem_q[rd_ptr_q].illegal;

endmodule
